// File: rtl/snp_pkg.sv
// rtl/snp_pkg.sv - shared parameters and types for the salt-and-pepper median filter
package snp_pkg;
    localparam int IMG_W  = 256;
    localparam int IMG_H  = 256;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 16;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [8:0] win_t;

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - circular row store; o_data is the word written DEPTH enabled cycles ago
module line_buffer #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;

    assign o_data = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (res) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_data;
        end
    end
endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster reader and 3x3 window generator feeding the median stage
module window_gen_3x3 #(
    parameter int IMG_W  = snp_pkg::IMG_W,
    parameter int IMG_H  = snp_pkg::IMG_H,
    parameter int PIX_W  = snp_pkg::PIX_W,
    parameter int ADDR_W = snp_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [PIX_W-1:0]     rd_data,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [9*PIX_W-1:0]   win_data,
    output logic [ADDR_W-1:0]    win_addr,
    output logic                 win_last
);
    import snp_pkg::*;

    localparam int N  = IMG_W * IMG_H;
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0]     C_N     = CW'(N);
    localparam logic [CW-1:0]     C_FIRST = CW'(IMG_W + 1);
    localparam logic [CW-1:0]     C_END   = CW'(N + IMG_W + 1);
    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] A_COL_L = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] A_ROW_L = ADDR_W'(IMG_H - 1);

    state_t              r_state, w_state_nx;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_all, r_rd_pend;
    logic [PIX_W-1:0]    r_skid [2];
    logic                r_skid_hd;
    logic [1:0]          r_skid_cnt;
    logic [CW-1:0]       r_in_cnt;
    logic [ADDR_W-1:0]   r_crow, r_ccol, r_cen_addr;
    logic [PIX_W-1:0]    r_cola [3];
    logic [PIX_W-1:0]    r_colb [3];
    logic                r_win_valid, r_win_last;
    logic [9*PIX_W-1:0]  r_win_data;
    logic [ADDR_W-1:0]   r_win_addr;

    logic                w_active, w_dummy, w_skid_ne, w_in_avail, w_out_free;
    logic                w_step, w_emit, w_pop, w_push, w_rd_en, w_border;
    logic [PIX_W-1:0]    w_in_pix, w_lb0, w_lb1;
    logic [9*PIX_W-1:0]  w_win;

    // Once all real pixels are consumed, IMG_W+1 dummy steps drain the bottom row from the buffers.
    assign w_active   = (r_state == FILL) || (r_state == RUN) || (r_state == FLUSH);
    assign w_dummy    = (r_in_cnt >= C_N);
    assign w_skid_ne  = (r_skid_cnt != 2'd0);
    assign w_in_avail = w_dummy || w_skid_ne || r_rd_pend;
    assign w_in_pix   = w_skid_ne ? r_skid[r_skid_hd] : rd_data;
    assign w_out_free = !r_win_valid || win_ready;
    assign w_step     = w_active && (r_in_cnt != C_END) && w_in_avail && w_out_free;
    assign w_emit     = w_step && (r_in_cnt >= C_FIRST);
    assign w_pop      = w_step && !w_dummy && w_skid_ne;
    assign w_push     = r_rd_pend && !(w_step && !w_skid_ne);

    // Only registered state gates a read, so its data always fits in the skid even if nothing drains.
    assign w_rd_en = ((r_state == FILL) || (r_state == RUN)) && !r_rd_all &&
                     ((r_skid_cnt == 2'd0) || ((r_skid_cnt == 2'd1) && !r_rd_pend));

    assign w_border = (r_crow == '0) || (r_crow == A_ROW_L) ||
                      (r_ccol == '0) || (r_ccol == A_COL_L);

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_mid (
        .clk    (clk),
        .res    (res),
        .i_en   (w_step),
        .i_data (w_in_pix),
        .o_data (w_lb0)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_top (
        .clk    (clk),
        .res    (res),
        .i_en   (w_step),
        .i_data (w_lb0),
        .o_data (w_lb1)
    );

    always_comb begin
        w_win = '0;
        for (int dr = 0; dr < 3; dr++) begin
            w_win[PIX_W*(3*dr)   +: PIX_W] = r_cola[dr];
            w_win[PIX_W*(3*dr+1) +: PIX_W] = r_colb[dr];
        end
        w_win[PIX_W*2 +: PIX_W] = w_lb1;
        w_win[PIX_W*5 +: PIX_W] = w_lb0;
        w_win[PIX_W*8 +: PIX_W] = w_in_pix;
        if (w_border) begin
            w_win = {9{r_colb[1]}};
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nx = FILL;
            FILL:    if (w_emit) w_state_nx = RUN;
            RUN:     if (w_rd_en && (r_rd_addr == A_LAST)) w_state_nx = FLUSH;
            FLUSH:   if (r_win_valid && win_ready && r_win_last) w_state_nx = DONE;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= IDLE;
            r_rd_addr   <= '0;
            r_rd_all    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_skid_hd   <= 1'b0;
            r_skid_cnt  <= 2'd0;
            r_in_cnt    <= '0;
            r_crow      <= '0;
            r_ccol      <= '0;
            r_cen_addr  <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_win_data  <= '0;
            r_win_addr  <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_rd_pend <= w_rd_en;
            if (r_state == IDLE) begin
                if (start) begin
                    r_rd_addr  <= '0;
                    r_rd_all   <= 1'b0;
                    r_skid_hd  <= 1'b0;
                    r_skid_cnt <= 2'd0;
                    r_in_cnt   <= '0;
                    r_crow     <= '0;
                    r_ccol     <= '0;
                    r_cen_addr <= '0;
                end
            end else begin
                if (w_rd_en) begin
                    if (r_rd_addr == A_LAST) r_rd_all <= 1'b1;
                    else                     r_rd_addr <= r_rd_addr + 1'b1;
                end
                if (w_pop) r_skid_hd <= ~r_skid_hd;
                r_skid_cnt <= r_skid_cnt + {1'b0, w_push} - {1'b0, w_pop};
                if (w_step) r_in_cnt <= r_in_cnt + 1'b1;
                if (w_emit) begin
                    r_win_valid <= 1'b1;
                    r_win_data  <= w_win;
                    r_win_addr  <= r_cen_addr;
                    r_win_last  <= (r_cen_addr == A_LAST);
                    if (r_ccol == A_COL_L) begin
                        r_ccol <= '0;
                        if (r_crow != A_ROW_L) r_crow <= r_crow + 1'b1;
                    end else begin
                        r_ccol <= r_ccol + 1'b1;
                    end
                    if (r_cen_addr != A_LAST) r_cen_addr <= r_cen_addr + 1'b1;
                end else if (win_ready) begin
                    r_win_valid <= 1'b0;
                    r_win_last  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_skid[r_skid_hd ^ r_skid_cnt[0]] <= rd_data;
        end
        if (w_step) begin
            for (int dr = 0; dr < 3; dr++) begin
                r_cola[dr] <= r_colb[dr];
            end
            r_colb[0] <= w_lb1;
            r_colb[1] <= w_lb0;
            r_colb[2] <= w_in_pix;
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign rd_en     = w_rd_en;
    assign rd_addr   = r_rd_addr;
    assign win_valid = r_win_valid;
    assign win_data  = r_win_data;
    assign win_addr  = r_win_addr;
    assign win_last  = r_win_last;
endmodule
